// File: rtl/apb_modport_pkg.sv
// ==== apb_modport_pkg : shared widths, depth and master FSM state type ====
// ==== Rev 1.0 =============================================================
`default_nettype none

package apb_modport_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int MEM_D  = 256;
  localparam int IDX_W  = $clog2(MEM_D);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Top address bit picks the slave: 0 -> slave1, 1 -> slave2.
  function automatic logic sel_slave2(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_mem_slave.sv
// ==== apb_mem_slave : 256x8 zero-wait-state APB memory slave ==============
// ==== Rev 1.0 =============================================================
`default_nettype none

module apb_mem_slave
  import apb_modport_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_psel,
  input  logic              i_penable,
  input  logic              i_pwrite,
  input  logic [IDX_W-1:0]  i_paddr,
  input  logic [DATA_W-1:0] i_pwdata,
  output logic [DATA_W-1:0] o_prdata,
  output logic              o_pready
);

  logic [DATA_W-1:0] r_mem [MEM_D];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_D; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_psel && i_penable && i_pwrite) begin
      r_mem[i_paddr] <= i_pwdata;
    end
  end

  assign o_pready = 1'b1;
  assign o_prdata = i_psel ? r_mem[i_paddr] : '0;

endmodule

`default_nettype wire

// File: rtl/apb_modport.sv
// ==== apb_modport : APB master FSM bridging a request port to two slaves ===
// ==== Rev 1.0 ==============================================================
`default_nettype none

module apb_modport
  import apb_modport_pkg::*;
(
  input  logic              pclk,
  input  logic              presetn,
  input  logic              transfer,
  input  logic              READ_WRITE,
  input  logic [ADDR_W-1:0] apb_write_paddr,
  input  logic [DATA_W-1:0] apb_write_data,
  input  logic [ADDR_W-1:0] apb_read_paddr,
  output logic [DATA_W-1:0] apb_read_data_out
);

  state_t            r_state;
  logic              r_psel1;
  logic              r_psel2;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] r_rdata;

  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_prdata1;
  logic [DATA_W-1:0] w_prdata2;
  logic [DATA_W-1:0] w_prdata;
  logic              w_pready1;
  logic              w_pready2;
  logic              w_pready;
  logic              w_done;
  logic              w_start;

  assign w_req_addr = READ_WRITE ? apb_read_paddr : apb_write_paddr;
  assign w_prdata   = sel_slave2(r_paddr) ? w_prdata2 : w_prdata1;
  assign w_pready   = sel_slave2(r_paddr) ? w_pready2 : w_pready1;
  assign w_done     = (r_state == ACCESS) && w_pready;
  // A new request is accepted from IDLE or on the edge that retires the current one.
  assign w_start    = transfer && ((r_state == IDLE) || w_done);

  always_ff @(posedge pclk) begin
    if (presetn) begin
      r_state   <= IDLE;
      r_psel1   <= 1'b0;
      r_psel2   <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_rdata   <= '0;
    end else begin
      if (w_done && !r_pwrite) begin
        r_rdata <= w_prdata;
      end
      if (w_start) begin
        r_state   <= SETUP;
        r_pwrite  <= ~READ_WRITE;
        r_paddr   <= w_req_addr;
        r_pwdata  <= apb_write_data;
        r_psel1   <= ~sel_slave2(w_req_addr);
        r_psel2   <= sel_slave2(w_req_addr);
        r_penable <= 1'b0;
      end else begin
        case (r_state)
          SETUP: begin
            r_state   <= ACCESS;
            r_penable <= 1'b1;
          end
          ACCESS: begin
            if (w_pready) begin
              r_state   <= IDLE;
              r_psel1   <= 1'b0;
              r_psel2   <= 1'b0;
              r_penable <= 1'b0;
            end
          end
          IDLE: begin
            r_state <= IDLE;
          end
          default: begin
            r_state   <= IDLE;
            r_psel1   <= 1'b0;
            r_psel2   <= 1'b0;
            r_penable <= 1'b0;
          end
        endcase
      end
    end
  end

  apb_mem_slave u_slave1 (
    .clk       (pclk),
    .rst       (presetn),
    .i_psel    (r_psel1),
    .i_penable (r_penable),
    .i_pwrite  (r_pwrite),
    .i_paddr   (r_paddr[IDX_W-1:0]),
    .i_pwdata  (r_pwdata),
    .o_prdata  (w_prdata1),
    .o_pready  (w_pready1)
  );

  apb_mem_slave u_slave2 (
    .clk       (pclk),
    .rst       (presetn),
    .i_psel    (r_psel2),
    .i_penable (r_penable),
    .i_pwrite  (r_pwrite),
    .i_paddr   (r_paddr[IDX_W-1:0]),
    .i_pwdata  (r_pwdata),
    .o_prdata  (w_prdata2),
    .o_pready  (w_pready2)
  );

  assign apb_read_data_out = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_apb_modport.sv
// ==== tb_apb_modport : directed self-checking bench for apb_modport =======
// ==== Rev 1.0 =============================================================
`default_nettype none

module tb_apb_modport;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       transfer;
  logic       READ_WRITE;
  logic [8:0] apb_write_paddr;
  logic [7:0] apb_write_data;
  logic [8:0] apb_read_paddr;
  logic [7:0] apb_read_data_out;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  always #5 pclk = ~pclk;

  apb_modport dut (
    .pclk              (pclk),
    .presetn           (presetn),
    .transfer          (transfer),
    .READ_WRITE        (READ_WRITE),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_paddr    (apb_read_paddr),
    .apb_read_data_out (apb_read_data_out)
  );

  // Model: one flat 512-byte space; a request accepted at edge N retires at edge N+2.
  logic [7:0] m_mem [512];
  logic [7:0] m_exp;
  bit         m_pend;
  bit         m_rd;
  logic [8:0] m_addr;
  logic [7:0] m_data;
  int         m_done;
  int         cyc = 0;

  always @(posedge pclk) begin
    cyc++;
    if (presetn) begin
      for (int i = 0; i < 512; i++) m_mem[i] = 8'h00;
      m_exp  = 8'h00;
      m_pend = 1'b0;
    end else begin
      if (m_pend && cyc == m_done) begin
        if (m_rd) m_exp = m_mem[m_addr];
        else      m_mem[m_addr] = m_data;
        m_pend = 1'b0;
      end
      if (!m_pend && transfer) begin
        m_pend = 1'b1;
        m_done = cyc + 2;
        m_rd   = READ_WRITE;
        m_addr = READ_WRITE ? apb_read_paddr : apb_write_paddr;
        m_data = apb_write_data;
      end
    end
  end

  always @(negedge pclk) begin
    if (armed) begin
      total++;
      if (apb_read_data_out !== m_exp) begin
        bad++;
        $display("FAIL cycle_cmp cyc=%0d rdata got=%h want=%h", cyc, apb_read_data_out, m_exp);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Pins both the DUT and the model to a hand-computed value.
  task automatic chk2(input string name, input logic [7:0] want);
    chk({name, "_dut"}, apb_read_data_out, want);
    chk({name, "_model"}, m_exp, want);
  endtask

  task automatic drive(input bit rd, input logic [8:0] a, input logic [7:0] d);
    transfer   = 1'b1;
    READ_WRITE = rd;
    // The unused address port carries a different value so a wrong mux shows up.
    apb_read_paddr  = rd ? a : ~a;
    apb_write_paddr = rd ? ~a : a;
    apb_write_data  = d;
  endtask

  task automatic txn(input bit rd, input logic [8:0] a, input logic [7:0] d);
    drive(rd, a, d);
    @(negedge pclk);
    transfer = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
  endtask

  bit         b_rd   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [8:0] b_addr [4] = '{9'h0FF, 9'h100, 9'h0FF, 9'h100};
  logic [7:0] b_data [4] = '{8'h11, 8'h22, 8'h00, 8'h00};

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    presetn = 1'b1; transfer = 1'b0; READ_WRITE = 1'b0;
    apb_write_paddr = '0; apb_write_data = '0; apb_read_paddr = '0;
    repeat (2) @(negedge pclk);
    presetn = 1'b0;
    armed   = 1'b1;
    chk2("reset", 8'h00);

    txn(1'b1, 9'h000, 8'h00); chk2("rd000", 8'h00);
    txn(1'b1, 9'h1FF, 8'h00); chk2("rd1FF", 8'h00);

    txn(1'b0, 9'h005, 8'h5A);
    txn(1'b1, 9'h005, 8'h00); chk2("rd005", 8'h5A);

    txn(1'b0, 9'h105, 8'hA5); chk2("hold_wr", 8'h5A);
    txn(1'b1, 9'h105, 8'h00); chk2("rd105", 8'hA5);
    txn(1'b1, 9'h005, 8'h00); chk2("rd005_indep", 8'h5A);

    // Inputs changed while in SETUP must not alter the transaction in flight.
    drive(1'b1, 9'h005, 8'h00);
    @(negedge pclk);
    transfer = 1'b0; READ_WRITE = 1'b0;
    apb_write_paddr = 9'h105; apb_read_paddr = 9'h105; apb_write_data = 8'hEE;
    @(negedge pclk);
    @(negedge pclk);
    chk2("setup_chg", 8'h5A);
    txn(1'b1, 9'h105, 8'h00); chk2("setup_chg_nowr", 8'hA5);

    for (int k = 0; k < 4; k++) begin
      drive(b_rd[k], b_addr[k], b_data[k]);
      @(negedge pclk);
      @(negedge pclk);
      if (k == 2) chk2("b2b_hold", 8'hA5);
      if (k == 3) chk2("b2b_rd0FF", 8'h11);
    end
    transfer = 1'b0;
    @(negedge pclk);
    chk2("b2b_rd100", 8'h22);

    // Reset lands on the ACCESS edge of a write: the write is lost.
    drive(1'b0, 9'h010, 8'h77);
    @(negedge pclk);
    transfer = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    presetn = 1'b0;
    chk2("mid_rst", 8'h00);
    txn(1'b1, 9'h010, 8'h00); chk2("rd010_dropped", 8'h00);
    txn(1'b1, 9'h0FF, 8'h00); chk2("rd0FF_cleared", 8'h00);
    txn(1'b0, 9'h010, 8'h3C);
    txn(1'b1, 9'h010, 8'h00); chk2("rd010_after", 8'h3C);

    repeat (2) @(negedge pclk);
    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
